core_run_ctrl: RTL and testbench
================================

// Module: core_run_ctrl
// PURPOSE
//   Synthesisable run controller for the single-cycle MIPS core. Generates a
//   synchronised, stretched core reset. Runs the core and counts cycles. Ends
//   the run on a masked status-flag condition that must persist for a set time
//   (e.g. zero). Also ends the run on a cycle budget. Sits between board
//   clock/reset and the core top; replaces fixed-delay bench sequencing.
// PARAMETERS
//   CNT_WIDTH    32   width of cycle counter
//   RST_HOLD     4    cycles core reset is held low after start (>=1)
//   MAX_CYCLES   100  run budget in cycles; 0 = no timeout
//   HALT_STABLE  3    consecutive cycles a masked flag must be high to halt (>=1)
//   NUM_FLAGS    1    number of watched core status flags
// PORTS
//   i_clk          in   1          system clock, rising edge
//   rst_n          in   1          asynchronous, active-low reset
//   i_start        in   1          start/restart run; sampled each rising edge
//   i_abort        in   1          abort run; sampled each rising edge
//   i_flags        in   NUM_FLAGS  core status flags (bit0 = core zero)
//   i_flag_mask    in   NUM_FLAGS  1 = flag participates in halt detection
//   o_core_rst_n   out  1          active-low reset to core
//   o_running      out  1          core is in RUN state
//   o_done         out  1          run ended by halt or timeout (sticky)
//   o_timeout      out  1          run ended by cycle budget (sticky)
//   o_cycle_count  out  CNT_WIDTH  cycles spent in RUN, frozen after run
//   o_halt_flags   out  NUM_FLAGS  masked flags captured at halt
// BEHAVIOUR
//   - Reset: async assert. Deassert goes through a 2-flop synchroniser; FSM leaves reset 2 edges later.
//   - Reset values: state=IDLE, o_core_rst_n=0, all other outputs 0.
//   - All outputs are registered.
//   - FSM states: IDLE, HOLD, RUN, DONE.
//   - IDLE: o_core_rst_n=0. On i_start -> HOLD; clear o_done, o_timeout, o_cycle_count, o_halt_flags.
//   - HOLD: o_core_rst_n=0 for exactly RST_HOLD cycles, then -> RUN.
//   - Start latency: o_core_rst_n rises RST_HOLD+1 edges after the edge that samples i_start.
//   - RUN: o_core_rst_n=1, o_running=1.
//     - o_cycle_count is 0 in the first RUN cycle and increments by 1 per edge.
//     - Counter saturates at all-ones and never wraps.
//   - Halt: stable counter increments while |(i_flags & i_flag_mask).
//     - Counter clears on any cycle where the masked OR is 0.
//     - When it reaches HALT_STABLE: -> DONE, o_done=1, o_halt_flags = i_flags & i_flag_mask.
//   - Timeout: MAX_CYCLES!=0 and o_cycle_count==MAX_CYCLES-1 in RUN -> DONE, o_done=1, o_timeout=1.
//   - Halt and timeout in the same cycle: halt wins, o_timeout=0.
//   - i_abort in HOLD or RUN -> IDLE next edge.
//     - o_core_rst_n=0 immediately registered; o_running=0.
//     - Count is retained; o_done stays 0.
//     - Abort has priority over halt, timeout and start.
//   - DONE: o_running=0, count frozen, o_core_rst_n stays 1 so core state is inspectable.
//     - i_start -> HOLD (re-run, clears status as from IDLE).
//     - i_abort -> IDLE.
//   - i_start while in HOLD or RUN is ignored.
//   - i_flag_mask=0: halt can never occur; only timeout or abort ends the run.
//   - rst_n low mid-run: everything returns to reset values asynchronously; no run resumes.
// TESTING
//   1 Reset: rst_n=0 then 1, 10 edges idle -> o_core_rst_n=0, o_done=0, count=0; no activity before 2-edge sync.
//   2 Start latency: pulse i_start, defaults -> o_core_rst_n rises exactly 5 edges after sample; o_running=1, count 0,1,2...
//   3 Halt: flags=1, mask=1, asserted from RUN cycle 10 for 3 cycles -> o_done=1, o_timeout=0, o_halt_flags=1, count frozen at 12.
//   4 Glitch + timeout: flag high 2 cycles, low 1, repeated; MAX_CYCLES=100 -> no halt; o_done=o_timeout=1, count=99.
//   5 Priority/abort: flag stable hits 3 exactly at count 99 -> halt wins, o_timeout=0. Separately, abort at count 40 with start same edge -> IDLE, core reset low, count=40, o_done=0.
//   6 Restart and reset mid-run: i_start in DONE -> status cleared, new run. rst_n low at count 20 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle MIPS core: stretched core reset, cycle
// counting, and run termination on a persistent masked status flag or a cycle budget.
module core_run_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int RST_HOLD    = 4,
  parameter int MAX_CYCLES  = 100,
  parameter int HALT_STABLE = 3,
  parameter int NUM_FLAGS   = 1
) (
  input  logic                 i_clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [NUM_FLAGS-1:0] i_flags,
  input  logic [NUM_FLAGS-1:0] i_flag_mask,
  output logic                 o_core_rst_n,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_cycle_count,
  output logic [NUM_FLAGS-1:0] o_halt_flags
);

  localparam int HOLD_W   = $clog2(RST_HOLD + 1);
  localparam int STABLE_W = $clog2(HALT_STABLE + 1);
  localparam bit HAS_TIMEOUT = (MAX_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] LAST_CYCLE =
    CNT_WIDTH'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RUN, ST_DONE} state_t;

  state_t              state_reg;
  logic [1:0]          sync_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic [STABLE_W-1:0] stable_reg;

  logic [NUM_FLAGS-1:0] masked_flags;
  logic                 flag_hit;
  logic                 halt_now;
  logic                 timeout_now;
  logic                 cnt_max;

  // Assert asynchronously, release only after two clean edges.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b00;
    else        sync_reg <= {sync_reg[0], 1'b1};
  end

  always_comb begin
    masked_flags = i_flags & i_flag_mask;
    flag_hit     = |masked_flags;
    halt_now     = flag_hit && (stable_reg == STABLE_W'(HALT_STABLE - 1));
    timeout_now  = HAS_TIMEOUT && (o_cycle_count == LAST_CYCLE);
    cnt_max      = &o_cycle_count;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= '0;
      stable_reg    <= '0;
      o_core_rst_n  <= 1'b0;
      o_running     <= 1'b0;
      o_done        <= 1'b0;
      o_timeout     <= 1'b0;
      o_cycle_count <= '0;
      o_halt_flags  <= '0;
    end else if (!sync_reg[1]) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= '0;
      stable_reg    <= '0;
      o_core_rst_n  <= 1'b0;
      o_running     <= 1'b0;
      o_done        <= 1'b0;
      o_timeout     <= 1'b0;
      o_cycle_count <= '0;
      o_halt_flags  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (i_abort) begin
            state_reg    <= ST_IDLE;
            o_core_rst_n <= 1'b0;
            o_running    <= 1'b0;
          end else if (i_start) begin
            state_reg     <= ST_HOLD;
            hold_reg      <= '0;
            stable_reg    <= '0;
            o_core_rst_n  <= 1'b0;
            o_running     <= 1'b0;
            o_done        <= 1'b0;
            o_timeout     <= 1'b0;
            o_cycle_count <= '0;
            o_halt_flags  <= '0;
          end
        end
        ST_HOLD: begin
          if (i_abort) begin
            state_reg    <= ST_IDLE;
            o_core_rst_n <= 1'b0;
            o_running    <= 1'b0;
          end else if (hold_reg == HOLD_W'(RST_HOLD)) begin
            state_reg    <= ST_RUN;
            o_core_rst_n <= 1'b1;
            o_running    <= 1'b1;
          end else begin
            hold_reg <= hold_reg + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            state_reg    <= ST_IDLE;
            o_core_rst_n <= 1'b0;
            o_running    <= 1'b0;
          end else if (halt_now) begin
            // Halt outranks a coincident timeout.
            state_reg    <= ST_DONE;
            o_running    <= 1'b0;
            o_done       <= 1'b1;
            o_halt_flags <= masked_flags;
          end else if (timeout_now) begin
            state_reg <= ST_DONE;
            o_running <= 1'b0;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            if (!cnt_max) o_cycle_count <= o_cycle_count + CNT_WIDTH'(1);
            stable_reg <= flag_hit ? stable_reg + STABLE_W'(1) : '0;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          o_core_rst_n <= 1'b0;
          o_running    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomised and directed checks of core_run_ctrl against a run-level model
// that predicts where each run ends from the flag sequence alone.
module tb_core_run_ctrl;

  logic        i_clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_abort;
  logic [0:0]  i_flags;
  logic [0:0]  i_flag_mask;
  logic        o_core_rst_n;
  logic        o_running;
  logic        o_done;
  logic        o_timeout;
  logic [31:0] o_cycle_count;
  logic [0:0]  o_halt_flags;

  int tests = 0;
  int fails = 0;

  // Per-run stimulus and observations
  bit          fv[128];
  int          rise_k;
  logic        post_done;
  logic [31:0] post_cnt;
  logic [31:0] obs_cnt[128];
  logic        obs_run[128];
  logic [31:0] fin_cnt;
  logic        fin_done, fin_timeout, fin_running, fin_core_rst_n;
  logic [0:0]  fin_halt;

  core_run_ctrl dut (
    .i_clk        (i_clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_flags      (i_flags),
    .i_flag_mask  (i_flag_mask),
    .o_core_rst_n (o_core_rst_n),
    .o_running    (o_running),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_cycle_count(o_cycle_count),
    .o_halt_flags (o_halt_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Run ends at the first cycle closing a streak of 3 masked-high flags,
  // otherwise at cycle 99 (100-cycle budget).
  function automatic void predict(input logic msk, output int end_c, output bit halted);
    int streak = 0;
    end_c  = 99;
    halted = 1'b0;
    for (int i = 0; i < 100; i++) begin
      streak = (fv[i] && msk) ? streak + 1 : 0;
      if (streak == 3) begin
        end_c  = i;
        halted = 1'b1;
        return;
      end
    end
  endfunction

  task automatic clear_fv();
    for (int i = 0; i < 128; i++) fv[i] = 1'b0;
  endtask

  // Start a run, drive fv[c] during RUN cycle c, optionally abort in cycle abort_at.
  task automatic do_run(input int n_run, input logic msk, input int abort_at);
    i_flag_mask = msk;
    i_flags     = 1'b0;
    i_start     = 1'b1;
    step();
    i_start   = 1'b0;
    post_done = o_done;
    post_cnt  = o_cycle_count;
    rise_k    = -1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (o_core_rst_n === 1'b1 && rise_k < 0) rise_k = k;
    end
    for (int c = 0; c < n_run; c++) begin
      obs_cnt[c] = o_cycle_count;
      obs_run[c] = o_running;
      if (c == abort_at) begin
        i_abort = 1'b1;
        i_start = 1'b1;
      end
      i_flags = fv[c];
      step();
      i_abort = 1'b0;
      i_start = 1'b0;
      i_flags = 1'b0;
    end
    fin_cnt        = o_cycle_count;
    fin_done       = o_done;
    fin_timeout    = o_timeout;
    fin_running    = o_running;
    fin_core_rst_n = o_core_rst_n;
    fin_halt       = o_halt_flags;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_flags = 1'b0; i_flag_mask = 1'b1;
    repeat (3) step();
    tests++;
    if ({o_core_rst_n, o_running, o_done, o_timeout, o_halt_flags} !== 5'b0 || o_cycle_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_hold: outputs %b cnt %0d expected all zero", {o_core_rst_n, o_running, o_done, o_timeout, o_halt_flags}, o_cycle_count);
    end
    // i_start during the synchroniser window must be ignored
    rst_n = 1'b1; i_start = 1'b1;
    step(); step();
    i_start = 1'b0;
    repeat (10) step();
    tests++;
    if (o_core_rst_n !== 1'b0 || o_running !== 1'b0) begin
      fails++;
      $display("FAIL reset_sync: core_rst_n %b running %b expected 0 0", o_core_rst_n, o_running);
    end
    tests++;
    if (o_done !== 1'b0 || o_cycle_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_idle: done %b cnt %0d expected 0 0", o_done, o_cycle_count);
    end
  endtask

  task automatic test_start_latency();
    int bad = 0;
    clear_fv();
    do_run(105, 1'b1, -1);
    tests++;
    if (rise_k !== 5) begin
      fails++;
      $display("FAIL start_latency: core_rst_n rose at edge %0d expected 5", rise_k);
    end
    for (int c = 0; c < 105; c++) begin
      int ec = (c < 99) ? c : 99;
      if (obs_cnt[c] !== 32'(ec) || obs_run[c] !== (c <= 99)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL count_trace: %0d bad cycles (cnt[0..2]=%0d,%0d,%0d) expected 0", bad, obs_cnt[0], obs_cnt[1], obs_cnt[2]);
    end
  endtask

  task automatic test_halt();
    clear_fv();
    fv[10] = 1'b1; fv[11] = 1'b1; fv[12] = 1'b1;
    do_run(30, 1'b1, -1);
    tests++;
    if (fin_cnt !== 32'd12 || fin_done !== 1'b1 || fin_timeout !== 1'b0 || fin_halt !== 1'b1) begin
      fails++;
      $display("FAIL halt: cnt %0d done %b to %b hf %b expected 12 1 0 1", fin_cnt, fin_done, fin_timeout, fin_halt);
    end
    tests++;
    if (fin_running !== 1'b0 || fin_core_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL halt_done_state: running %b core_rst_n %b expected 0 1", fin_running, fin_core_rst_n);
    end
  endtask

  task automatic test_glitch_timeout();
    clear_fv();
    for (int i = 0; i < 128; i++) fv[i] = ((i % 3) != 2);
    do_run(105, 1'b1, -1);
    tests++;
    if (fin_cnt !== 32'd99 || fin_done !== 1'b1 || fin_timeout !== 1'b1 || fin_halt !== 1'b0) begin
      fails++;
      $display("FAIL glitch_timeout: cnt %0d done %b to %b hf %b expected 99 1 1 0", fin_cnt, fin_done, fin_timeout, fin_halt);
    end
  endtask

  task automatic test_priority();
    clear_fv();
    fv[97] = 1'b1; fv[98] = 1'b1; fv[99] = 1'b1;
    do_run(105, 1'b1, -1);
    tests++;
    if (fin_cnt !== 32'd99 || fin_done !== 1'b1 || fin_timeout !== 1'b0 || fin_halt !== 1'b1) begin
      fails++;
      $display("FAIL halt_beats_timeout: cnt %0d done %b to %b hf %b expected 99 1 0 1", fin_cnt, fin_done, fin_timeout, fin_halt);
    end
  endtask

  task automatic test_restart();
    clear_fv();
    fv[5] = 1'b1; fv[6] = 1'b1; fv[7] = 1'b1;
    do_run(20, 1'b1, -1);
    tests++;
    if (post_done !== 1'b0 || post_cnt !== 32'd0) begin
      fails++;
      $display("FAIL restart_clear: done %b cnt %0d after start expected 0 0", post_done, post_cnt);
    end
    tests++;
    if (fin_cnt !== 32'd7 || fin_done !== 1'b1 || fin_timeout !== 1'b0) begin
      fails++;
      $display("FAIL restart_run: cnt %0d done %b to %b expected 7 1 0", fin_cnt, fin_done, fin_timeout);
    end
  endtask

  task automatic test_abort();
    clear_fv();
    for (int i = 38; i < 42; i++) fv[i] = 1'b1;
    do_run(41, 1'b1, 40);
    tests++;
    if (fin_cnt !== 32'd40 || fin_done !== 1'b0 || fin_core_rst_n !== 1'b0 || fin_running !== 1'b0) begin
      fails++;
      $display("FAIL abort: cnt %0d done %b core_rst_n %b running %b expected 40 0 0 0", fin_cnt, fin_done, fin_core_rst_n, fin_running);
    end
    repeat (8) step();
    tests++;
    if (o_core_rst_n !== 1'b0 || o_cycle_count !== 32'd40) begin
      fails++;
      $display("FAIL abort_idle: core_rst_n %b cnt %0d expected 0 40", o_core_rst_n, o_cycle_count);
    end
  endtask

  task automatic test_mask_off();
    for (int i = 0; i < 128; i++) fv[i] = 1'b1;
    do_run(105, 1'b0, -1);
    tests++;
    if (fin_cnt !== 32'd99 || fin_timeout !== 1'b1 || fin_halt !== 1'b0) begin
      fails++;
      $display("FAIL mask_off: cnt %0d to %b hf %b expected 99 1 0", fin_cnt, fin_timeout, fin_halt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int  end_c;
      bit  halted;
      int  bad = 0;
      int  thr = $urandom_range(3, 8);
      logic msk = (it == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < 128; i++) fv[i] = ($urandom_range(0, 9) < thr);
      predict(msk, end_c, halted);
      do_run(105, msk, -1);
      for (int c = 0; c < 105; c++) begin
        int ec = (c < end_c) ? c : end_c;
        if (obs_cnt[c] !== 32'(ec) || obs_run[c] !== (c <= end_c)) bad++;
      end
      tests++;
      if (rise_k !== 5 || bad != 0) begin
        fails++;
        $display("FAIL rand%0d_trace: rise %0d bad %0d expected 5 0", it, rise_k, bad);
      end
      tests++;
      if (fin_cnt !== 32'(end_c) || fin_done !== 1'b1 || fin_timeout !== !halted || fin_halt !== 1'(halted)) begin
        fails++;
        $display("FAIL rand%0d_end: cnt %0d done %b to %b hf %b expected %0d 1 %b %b", it, fin_cnt, fin_done, fin_timeout, fin_halt, end_c, !halted, halted);
      end
    end
  endtask

  task automatic test_reset_midrun();
    clear_fv();
    i_flag_mask = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (25) step();
    tests++;
    if (o_cycle_count !== 32'd20 || o_running !== 1'b1) begin
      fails++;
      $display("FAIL midrun_pre: cnt %0d running %b expected 20 1", o_cycle_count, o_running);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({o_core_rst_n, o_running, o_done, o_timeout, o_halt_flags} !== 5'b0 || o_cycle_count !== 32'd0) begin
      fails++;
      $display("FAIL midrun_async: outputs %b cnt %0d expected all zero", {o_core_rst_n, o_running, o_done, o_timeout, o_halt_flags}, o_cycle_count);
    end
    step(); step();
    rst_n = 1'b1;
    repeat (12) step();
    tests++;
    if (o_running !== 1'b0 || o_core_rst_n !== 1'b0 || o_cycle_count !== 32'd0) begin
      fails++;
      $display("FAIL midrun_no_resume: running %b core_rst_n %b cnt %0d expected 0 0 0", o_running, o_core_rst_n, o_cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_halt();
    test_glitch_timeout();
    test_priority();
    test_restart();
    test_abort();
    test_mask_off();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
